scandoubler_linebuf: RTL
========================

Name: scandoubler_linebuf

Overview:
- Parametrised line-buffered scandoubler, successor to the plain video mux stage on the VGA path.
- Captures each 15 kHz input line into a ping-pong line buffer and replays it twice at double pixel rate to produce 31 kHz VGA.
- Adds measured hsync regeneration, bit-replicated colour expansion and selectable scanline attenuation.
- Bypass mode keeps the 15 kHz passthrough: csync on h_sync, v_sync held high.

Parameters:
- IN_BITS, 3, input bits per colour channel; video_in is packed {R,G,B}.
- OUT_BITS, 4, output bits per channel; legal range IN_BITS..2*IN_BITS.
- ADDR_W, 10, line buffer address width; each bank holds 2**ADDR_W pixels.

Ports:
- clk_peripheral  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- ce_in  in  1  input pixel strobe (1x pixel rate).
- ce_out  in  1  output pixel strobe; exactly twice the ce_in rate.
- video_in  in  3*IN_BITS  input pixel {R,G,B}.
- hsync_in  in  1  input hsync, active-low.
- vsync_in  in  1  input vsync, active-low.
- csync_n  in  1  composite sync, used in bypass.
- scandouble  in  1  1 = doubled output, 0 = bypass.
- scanlines  in  2  0 off, 1 = 75% brightness, 2 = 50%, 3 = 25% on replayed lines.
- r, g, b  out  OUT_BITS each  output colour.
- h_sync  out  1  output hsync, active-low.
- v_sync  out  1  output vsync, active-low.
- line_overflow  out  1  sticky: an input line exceeded buffer depth.

Behaviour:
- Reset values: r = g = b = 0; h_sync = 1; v_sync = 1; line_overflow = 0. Internally wr_addr = rd_addr = 0, line_len = 0, hs_width = 0, both bank selects = 0, out_line = 0. The sync-edge detector's previous-sample register resets to 1 (no spurious edge after reset).
- Input side, each ce_in:
  - Write video_in to bank wr_bank at wr_addr.
  - wr_addr increments and saturates at 2**ADDR_W-1. Once saturated, further writes overwrite the last location and line_overflow is set.
  - hs_cnt counts ce_in cycles while hsync_in = 0 and clears while it is 1.
- Line end is a falling edge of hsync_in, sampled on ce_in. On line end:
  - line_len <= wr_addr (pixels written before the edge; the edge pixel is written at address 0 of the new line).
  - wr_addr <= 1; wr_bank toggles; rd_bank <= old wr_bank.
  - rd_addr <= 0; out_line <= 0.
  - v_sync_pending <= vsync_in.
- Latch hs_width <= hs_cnt on the rising edge of hsync_in.
- Output side, each ce_out (not a line-end cycle):
  - rd_addr increments.
  - When rd_addr = line_len-1, rd_addr wraps to 0 and out_line toggles (first pass 0, replay 1).
  - If line_len = 0, rd_addr stays 0.
- A line end on the same cycle as ce_out takes priority: rd_addr = 0, out_line = 0.
- Doubled output pipeline: synchronous buffer read (1 clock) then output register (1 clock), so pixels appear 2 clocks after the ce_out that addressed them. Syncs are delayed to match.
  - h_sync = 0 while rd_addr < hs_width, else 1. The output pulse is hs_width ce_out cycles, half the input duration in time.
  - v_sync <= v_sync_pending, updated when out_line = 0 and rd_addr = 0.
  - Until the first complete line has been captured (line_len = 0): r = g = b = 0, h_sync = 1, v_sync = 1.
- Colour expansion: out = {c, c[IN_BITS-1 -: OUT_BITS-IN_BITS]} (MSB replication; identity when the widths are equal). Examples for 3 to 4 bits: 3'b101 -> 4'b1011, 3'b111 -> 4'hF, 3'b000 -> 4'h0.
- Scanlines, applied after expansion, only when out_line = 1:
  - Mode 1: c - (c>>2).
  - Mode 2: c>>1.
  - Mode 3: c>>2.
  - All results are truncated to OUT_BITS; no overflow is possible.
- Bypass (scandouble = 0), registered every clock with latency 1:
  - r, g, b = expand(video_in).
  - h_sync = csync_n; v_sync = 1; no scanlines.
  - Buffer capture continues so that switching back is seamless from the next line.
- A change of scandouble or scanlines takes effect on the next clock. A partial output line is allowed.
- Reset mid-line discards buffer contents logically (line_len = 0); RAM contents are not cleared.

Test Plan:
- Reset then idle -> r = g = b = 0, h_sync = 1, v_sync = 1, line_overflow = 0 for 100 clocks.
- IN_BITS = 3, OUT_BITS = 4, scandouble = 1: 64-pixel lines with pixel n = n[8:0] and an 8-pixel hsync -> each line output twice in order, r = expand(n[8:6]), 2 clocks after ce_out. h_sync is low for 8 ce_out cycles at the start of each replay.
- scanlines = 2 with a constant pixel 9'h1FF -> first pass r = g = b = 4'hF, replay 4'h7. scanlines = 1 gives F then C; scanlines = 3 gives F then 3.
- Line of 2**ADDR_W + 5 pixels -> line_overflow = 1 and stays 1. The next line has line_len = 2**ADDR_W; reset clears the flag.
- scandouble = 0 -> r follows expand(video_in) with 1-clock latency, h_sync = csync_n, v_sync = 1. Toggle back to 1 -> doubled output resumes from the next input line end.
- vsync_in low for 2 input lines -> v_sync low for exactly 4 output lines, aligned to a replay-pair start.

Source files
------------

// File: rtl/scandoubler_linebuf.sv
// scandoubler_linebuf
//   Line-buffered 15 kHz -> 31 kHz scandoubler. Each input line is captured
//   into one bank of a ping-pong line buffer while the previous line is
//   replayed twice from the other bank at the doubled pixel rate. Output
//   hsync width is taken from the measured input hsync width. Colours are
//   widened by MSB replication, and replayed lines can be dimmed
//   (scanlines). Bypass mode passes the 15 kHz picture straight through with
//   composite sync.
//
// Ports
//   clk_peripheral  single clock, rising edge
//   reset           synchronous, active-high
//   ce_in           input pixel strobe (1x)
//   ce_out          output pixel strobe (exactly 2x ce_in)
//   video_in        input pixel {R,G,B}, IN_BITS per channel
//   hsync_in        input hsync, active-low
//   vsync_in        input vsync, active-low
//   csync_n         composite sync, routed to h_sync in bypass
//   scandouble      1 = doubled output, 0 = bypass
//   scanlines       replay dimming: 0 off, 1 75%, 2 50%, 3 25%
//   r, g, b         output colour, OUT_BITS per channel
//   h_sync, v_sync  output syncs, active-low
//   line_overflow   sticky: an input line exceeded the buffer depth
module scandoubler_linebuf #(
   parameter int IN_BITS  = 3,
   parameter int OUT_BITS = 4,
   parameter int ADDR_W   = 10
) (
   input  logic                 clk_peripheral,
   input  logic                 reset,
   input  logic                 ce_in,
   input  logic                 ce_out,
   input  logic [3*IN_BITS-1:0] video_in,
   input  logic                 hsync_in,
   input  logic                 vsync_in,
   input  logic                 csync_n,
   input  logic                 scandouble,
   input  logic [1:0]           scanlines,
   output logic [OUT_BITS-1:0]  r,
   output logic [OUT_BITS-1:0]  g,
   output logic [OUT_BITS-1:0]  b,
   output logic                 h_sync,
   output logic                 v_sync,
   output logic                 line_overflow
);

   localparam int PIX_W = 3*IN_BITS;
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   LEN_FULL = {1'b1, {ADDR_W{1'b0}}};

   // MSB replication; for OUT_BITS <= 2*IN_BITS this equals
   // {c, c[IN_BITS-1 -: OUT_BITS-IN_BITS]} and is identity at equal widths.
   function automatic logic [OUT_BITS-1:0] expand(input logic [IN_BITS-1:0] c);
      logic [OUT_BITS-1:0] e;
      e = '0;
      for (int unsigned i = 0; i < OUT_BITS; i++)
         e[OUT_BITS-1-i] = c[IN_BITS-1-(i % IN_BITS)];
      return e;
   endfunction

   function automatic logic [OUT_BITS-1:0] attenuate(input logic [OUT_BITS-1:0] c,
                                                     input logic             replay,
                                                     input logic [1:0]       mode);
      logic [OUT_BITS-1:0] o;
      o = c;
      if (replay) begin
         case (mode)
            2'd1:    o = c - (c >> 2);
            2'd2:    o = c >> 1;
            2'd3:    o = c >> 2;
            default: o = c;
         endcase
      end
      return o;
   endfunction

   // Line buffer: bank select is the MSB of the address.
   logic [PIX_W-1:0] line_mem [2**(ADDR_W+1)];

   // Input side
   logic              hs_prev_q, hs_prev_d;
   logic [ADDR_W:0]   hs_cnt_q, hs_cnt_d;
   logic [ADDR_W:0]   hs_width_q, hs_width_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic              wr_full_q, wr_full_d;
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic [ADDR_W:0]   line_len_q, line_len_d;
   logic              vs_pend_q, vs_pend_d;
   logic              overflow_q, overflow_d;

   // Output side
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              out_line_q, out_line_d;
   logic [PIX_W-1:0]  rd_data_q;
   logic              s1_valid_q, s1_valid_d;
   logic              s1_line_q, s1_line_d;
   logic              s1_hs_q, s1_hs_d;
   logic              s1_vs_q, s1_vs_d;
   logic [OUT_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
   logic              h_sync_q, h_sync_d;
   logic              v_sync_q, v_sync_d;

   logic              line_end;
   logic              hs_rise;
   logic              wr_bank_sel;
   logic [ADDR_W-1:0] wr_addr_sel;

   assign line_end    = ce_in & hs_prev_q & ~hsync_in;
   assign hs_rise     = ce_in & ~hs_prev_q & hsync_in;
   // The pixel that carries the hsync edge is the first pixel of the new line.
   assign wr_bank_sel = line_end ? ~wr_bank_q : wr_bank_q;
   assign wr_addr_sel = line_end ? '0 : wr_addr_q;

   always_ff @(posedge clk_peripheral) begin
      if (ce_in)
         line_mem[{wr_bank_sel, wr_addr_sel}] <= video_in;
   end

   always_ff @(posedge clk_peripheral) begin
      if (reset)
         rd_data_q <= '0;
      else if (ce_out)
         rd_data_q <= line_mem[{rd_bank_q, rd_addr_q}];
   end

   always_comb begin
      hs_prev_d  = hs_prev_q;
      hs_cnt_d   = hs_cnt_q;
      hs_width_d = hs_width_q;
      wr_addr_d  = wr_addr_q;
      wr_full_d  = wr_full_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      line_len_d = line_len_q;
      vs_pend_d  = vs_pend_q;
      overflow_d = overflow_q;

      if (ce_in) begin
         hs_prev_d = hsync_in;
         if (hsync_in)
            hs_cnt_d = '0;
         else if (hs_cnt_q != '1)
            hs_cnt_d = hs_cnt_q + LEN_ONE;
      end
      if (hs_rise)
         hs_width_d = hs_cnt_q;

      if (line_end) begin
         // wr_full_q marks that the last location was written, so the line
         // holds a full bank even though wr_addr saturated one short.
         line_len_d = wr_full_q ? LEN_FULL : {1'b0, wr_addr_q};
         wr_addr_d  = ADDR_ONE;
         wr_full_d  = 1'b0;
         wr_bank_d  = ~wr_bank_q;
         rd_bank_d  = wr_bank_q;
         vs_pend_d  = vsync_in;
      end else if (ce_in) begin
         if (wr_addr_q == ADDR_MAX) begin
            if (wr_full_q)
               overflow_d = 1'b1;
            wr_full_d = 1'b1;
         end else begin
            wr_addr_d = wr_addr_q + ADDR_ONE;
         end
      end
   end

   always_comb begin
      rd_addr_d  = rd_addr_q;
      out_line_d = out_line_q;
      s1_valid_d = s1_valid_q;
      s1_line_d  = s1_line_q;
      s1_hs_d    = s1_hs_q;
      s1_vs_d    = s1_vs_q;

      if (line_end) begin
         rd_addr_d  = '0;
         out_line_d = 1'b0;
      end else if (ce_out && line_len_q != '0) begin
         if (({1'b0, rd_addr_q} + LEN_ONE) == line_len_q) begin
            rd_addr_d  = '0;
            out_line_d = ~out_line_q;
         end else begin
            rd_addr_d = rd_addr_q + ADDR_ONE;
         end
      end

      // Stage 1 metadata travels with the buffer read so syncs stay aligned.
      if (ce_out) begin
         s1_valid_d = (line_len_q != '0);
         s1_line_d  = out_line_q;
         s1_hs_d    = ~({1'b0, rd_addr_q} < hs_width_q);
         if (!out_line_q && rd_addr_q == '0)
            s1_vs_d = vs_pend_q;
      end
   end

   always_comb begin
      r_d      = '0;
      g_d      = '0;
      b_d      = '0;
      h_sync_d = 1'b1;
      v_sync_d = 1'b1;
      if (!scandouble) begin
         r_d      = expand(video_in[3*IN_BITS-1 -: IN_BITS]);
         g_d      = expand(video_in[2*IN_BITS-1 -: IN_BITS]);
         b_d      = expand(video_in[IN_BITS-1:0]);
         h_sync_d = csync_n;
      end else if (s1_valid_q) begin
         r_d      = attenuate(expand(rd_data_q[3*IN_BITS-1 -: IN_BITS]), s1_line_q, scanlines);
         g_d      = attenuate(expand(rd_data_q[2*IN_BITS-1 -: IN_BITS]), s1_line_q, scanlines);
         b_d      = attenuate(expand(rd_data_q[IN_BITS-1:0]), s1_line_q, scanlines);
         h_sync_d = s1_hs_q;
         v_sync_d = s1_vs_q;
      end
   end

   always_ff @(posedge clk_peripheral) begin
      if (reset) begin
         hs_prev_q  <= 1'b1;
         hs_cnt_q   <= '0;
         hs_width_q <= '0;
         wr_addr_q  <= '0;
         wr_full_q  <= 1'b0;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         line_len_q <= '0;
         vs_pend_q  <= 1'b1;
         overflow_q <= 1'b0;
         rd_addr_q  <= '0;
         out_line_q <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_line_q  <= 1'b0;
         s1_hs_q    <= 1'b1;
         s1_vs_q    <= 1'b1;
         r_q        <= '0;
         g_q        <= '0;
         b_q        <= '0;
         h_sync_q   <= 1'b1;
         v_sync_q   <= 1'b1;
      end else begin
         hs_prev_q  <= hs_prev_d;
         hs_cnt_q   <= hs_cnt_d;
         hs_width_q <= hs_width_d;
         wr_addr_q  <= wr_addr_d;
         wr_full_q  <= wr_full_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         line_len_q <= line_len_d;
         vs_pend_q  <= vs_pend_d;
         overflow_q <= overflow_d;
         rd_addr_q  <= rd_addr_d;
         out_line_q <= out_line_d;
         s1_valid_q <= s1_valid_d;
         s1_line_q  <= s1_line_d;
         s1_hs_q    <= s1_hs_d;
         s1_vs_q    <= s1_vs_d;
         r_q        <= r_d;
         g_q        <= g_d;
         b_q        <= b_d;
         h_sync_q   <= h_sync_d;
         v_sync_q   <= v_sync_d;
      end
   end

   assign r             = r_q;
   assign g             = g_q;
   assign b             = b_q;
   assign h_sync        = h_sync_q;
   assign v_sync        = v_sync_q;
   assign line_overflow = overflow_q;

endmodule
